demux1to4_32bits_fifo: RTL and testbench

- Inverse of the team's 4:1 / 2:1 32-bit select muxes: one producer stream is steered to one of four consumer lanes.
- Each lane has its own small FIFO, so a stalled consumer does not block traffic to the other lanes.
- Used between fetch/decode and the four VLIW issue slots to route single operations, or to broadcast an operation to every slot.
- Valid/ready handshake on input and on each output lane.

---
 rtl/demux1to4_32bits_fifo.sv | 56 +++++
 tb/tb_demux1to4_32bits_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/demux1to4_32bits_fifo.sv
// demux1to4_32bits_fifo: steers one valid/ready word stream into four independent lane FIFOs,
// either to the lane picked by in_sel or to all four lanes at once (broadcast).
module demux1to4_32bits_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [1:0]                      in_sel,
  input  logic                            in_bcast,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [4*WIDTH-1:0]              out_data,
  output logic [3:0]                      out_valid,
  input  logic [3:0]                      out_ready,
  output logic [4*($clog2(DEPTH)+1)-1:0]  lane_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [3:0] full;
  logic [3:0] push;
  logic [3:0] pop;
  // Readiness uses pre-pop occupancy only, so there is no ready-through-pop path.
  always_comb begin
    in_ready = in_bcast ? ~|full : ~full[in_sel];
    push     = (in_valid && in_ready) ? (in_bcast ? 4'hf : 4'b0001 << in_sel) : 4'h0;
    pop      = out_valid & out_ready;
  end
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    // Memory is cleared on reset so stale words can never resurface after a reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push[k]) begin
          mem[tail] <= in_data;
          tail      <= tail + AW'(1);
        end
        if (pop[k]) head <= head + AW'(1);
        count <= count + CW'(push[k]) - CW'(pop[k]);
      end
    end
    assign full[k]                  = count == CW'(DEPTH);
    assign out_valid[k]             = count != '0;
    assign out_data[k*WIDTH +: WIDTH] = mem[head];
    assign lane_count[k*CW +: CW]   = count;
  end
endmodule

// File: tb/tb_demux1to4_32bits_fifo.sv
// tb_demux1to4_32bits_fifo: table-driven and randomized checks of the 1:4 lane FIFO demux
// against a queue-based reference model.
module tb_demux1to4_32bits_fifo;
  localparam int DEPTH = 2;
  logic        clk;
  logic        reset_n;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [127:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  lane_count;

  demux1to4_32bits_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .lane_count(lane_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        bc;
    logic        v;
    logic [3:0]  rdy;
    logic [31:0] d;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] q[4][$];
  logic [31:0] seen0[$];
  logic        rdy_seen;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic model_ready(input logic [1:0] sel, input logic bc);
    logic r = 1'b1;
    for (int k = 0; k < 4; k++) if ((bc || sel == k) && q[k].size() >= DEPTH) r = 1'b0;
    return r;
  endfunction

  task automatic check_model();
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = q[k].size() != 0;
    chk("out_valid", out_valid, ev);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("count%0d", k), lane_count[k*2 +: 2], q[k].size());
      if (q[k].size() != 0) chk($sformatf("head%0d", k), out_data[k*32 +: 32], q[k][0]);
    end
  endtask

  task automatic apply(input logic [1:0] sel, input logic bc, input logic v,
                       input logic [3:0] rdy, input logic [31:0] d);
    logic       er;
    logic [3:0] pop;
    in_sel = sel; in_bcast = bc; in_valid = v; out_ready = rdy; in_data = d;
    #1;
    er = model_ready(sel, bc);
    rdy_seen = in_ready;
    chk("in_ready", in_ready, er);
    pop = '0;
    for (int k = 0; k < 4; k++) pop[k] = rdy[k] && q[k].size() != 0;
    if (pop[0]) seen0.push_back(out_data[31:0]);
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (pop[k]) void'(q[k].pop_front());
    if (v && er) for (int k = 0; k < 4; k++) if (bc || sel == k) q[k].push_back(d);
    #1;
    check_model();
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic bc, input logic v,
                              input logic [3:0] rdy, input logic [31:0] d, input logic er,
                              input logic [3:0] ev, input logic [7:0] ec);
    vec_t t;
    t.sel = sel; t.bc = bc; t.v = v; t.rdy = rdy; t.d = d;
    t.exp_ready = er; t.exp_valid = ev; t.exp_cnt = ec;
    return t;
  endfunction

  initial begin
    // unicast routing, then drain
    tbl.push_back(mk(0, 0, 1, 4'b0000, 32'hA0000000, 1, 4'b0001, 8'h01));
    tbl.push_back(mk(1, 0, 1, 4'b0000, 32'hA0000001, 1, 4'b0011, 8'h05));
    tbl.push_back(mk(2, 0, 1, 4'b0000, 32'hA0000002, 1, 4'b0111, 8'h15));
    tbl.push_back(mk(3, 0, 1, 4'b0000, 32'hA0000003, 1, 4'b1111, 8'h55));
    tbl.push_back(mk(0, 0, 0, 4'b1111, 32'h0,        1, 4'b0000, 8'h00));
    // lane 2 full and backpressure, no ready-through-pop
    tbl.push_back(mk(2, 0, 1, 4'b0000, 32'h11, 1, 4'b0100, 8'h10));
    tbl.push_back(mk(2, 0, 1, 4'b0000, 32'h22, 1, 4'b0100, 8'h20));
    tbl.push_back(mk(2, 0, 1, 4'b0000, 32'h33, 0, 4'b0100, 8'h20));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 32'h33, 1, 4'b0100, 8'h20));
    tbl.push_back(mk(2, 0, 1, 4'b0100, 32'h33, 0, 4'b0100, 8'h10));
    tbl.push_back(mk(2, 0, 1, 4'b0000, 32'h33, 1, 4'b0100, 8'h20));
    tbl.push_back(mk(2, 0, 0, 4'b0100, 32'h0,  0, 4'b0100, 8'h10));
    tbl.push_back(mk(2, 0, 0, 4'b0100, 32'h0,  1, 4'b0000, 8'h00));
    // broadcast with lane 3 partially filled, then blocked broadcast
    tbl.push_back(mk(3, 0, 1, 4'b0000, 32'h55,       1, 4'b1000, 8'h40));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'hDEADBEEF, 1, 4'b1111, 8'h95));
    tbl.push_back(mk(0, 0, 0, 4'b1000, 32'h0,        1, 4'b1111, 8'h55));
    tbl.push_back(mk(3, 0, 1, 4'b0000, 32'h66,       1, 4'b1111, 8'h95));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h77,       0, 4'b1111, 8'h95));
    tbl.push_back(mk(0, 0, 0, 4'b1111, 32'h0,        1, 4'b1000, 8'h40));
    tbl.push_back(mk(0, 0, 0, 4'b1111, 32'h0,        1, 4'b0000, 8'h00));

    reset_n = 0; in_data = 0; in_sel = 0; in_bcast = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_count", lane_count, 8'h00);
    chk("rst_data", out_data, 128'h0);
    reset_n = 1;
    #1;
    chk("idle_ready", in_ready, 1'b1);
    apply(0, 0, 0, 4'b0000, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].sel, tbl[i].bc, tbl[i].v, tbl[i].rdy, tbl[i].d);
      chk($sformatf("tbl%0d_ready", i), rdy_seen, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_count", i), lane_count, tbl[i].exp_cnt);
    end
    chk("bcast_lane3_order", out_valid, 4'b0000);

    // streaming through lane 0 with simultaneous push/pop; pointers wrap five times
    seen0.delete();
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 1, 4'b0001, 32'(i + 1));
      chk("stream_ready", rdy_seen, 1'b1);
      chk("stream_cnt_le1", lane_count[1:0] <= 2'd1, 1'b1);
    end
    apply(0, 0, 0, 4'b0001, 32'h0);
    chk("stream_len", seen0.size(), 10);
    for (int i = 0; i < seen0.size(); i++) chk($sformatf("stream_word%0d", i), seen0[i], i + 1);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++)
      apply(2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 15)), $urandom);
    repeat (3) apply(0, 0, 0, 4'b1111, 32'h0);

    // asynchronous reset with lanes holding 2,1,0,2 entries
    apply(0, 0, 1, 4'b0000, 32'hB0000001);
    apply(0, 0, 1, 4'b0000, 32'hB0000002);
    apply(1, 0, 1, 4'b0000, 32'hB0000003);
    apply(3, 0, 1, 4'b0000, 32'hB0000004);
    apply(3, 0, 1, 4'b0000, 32'hB0000005);
    chk("pre_rst_count", lane_count, 8'h86);
    #2 reset_n = 0;
    #1;
    chk("async_rst_valid", out_valid, 4'b0000);
    chk("async_rst_count", lane_count, 8'h00);
    for (int k = 0; k < 4; k++) q[k].delete();
    @(negedge clk) reset_n = 1;
    repeat (2) apply(0, 0, 0, 4'b1111, 32'h0);
    apply(0, 0, 1, 4'b0000, 32'hCAFE0001);
    chk("post_rst_head", out_data[31:0], 32'hCAFE0001);
    chk("post_rst_count", lane_count, 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
